// File: rtl/smp_bus_arbiter.sv
// rtl/smp_bus_arbiter.sv - round-robin owner arbiter for the shared SMP bus
module smp_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32,
  parameter int HOLD_MAX  = 8,
  localparam int ID_W     = $clog2(NUM_CORES),
  localparam int CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_rw,
  input  logic [NUM_CORES*DATA_W-1:0] core_data,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic                        bus_grant,
  output logic                        bus_request,
  output logic                        bus_rw_req,
  output logic [DATA_W-1:0]           bus_data_in,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [ID_W-1:0]             owner_id,
  output logic                        timeout
);

  typedef enum logic [1:0] {IDLE, REQ, OWN, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ID_W-1:0]       prev_owner_q, prev_owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  rw_q, rw_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_CORES-1:0]  grant_q, grant_d;
  logic                  timeout_q, timeout_d;

  logic [DATA_W-1:0]     data_arr [NUM_CORES];
  logic [ID_W-1:0]       win;
  logic                  done_hit, req_drop, limit_hit;

  // Per-core data slices as an array so the owner can be selected by index
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slice
    assign data_arr[i] = core_data[i*DATA_W +: DATA_W];
  end

  // First requesting core strictly after the last owner, wrapping around
  function automatic logic [ID_W-1:0] next_owner(input logic [NUM_CORES-1:0] req,
                                                 input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = NUM_CORES; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_CORES;
      if (req[ID_W'(idx)]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  // Next-state and next-output computation for the ownership FSM
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    prev_owner_d = prev_owner_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    rw_d         = rw_q;
    data_d       = data_q;
    grant_d      = grant_q;
    timeout_d    = 1'b0;
    win          = next_owner(core_req, owner_q);
    done_hit     = core_done[owner_q];
    req_drop     = !core_req[owner_q];
    limit_hit    = (cnt_q == CNT_W'(HOLD_MAX - 1));
    case (state_q)
      IDLE: begin
        if (|core_req) begin
          prev_owner_d = owner_q;
          owner_d      = win;
          req_d        = 1'b1;
          rw_d         = core_rw[win];
          data_d       = data_arr[win];
          state_d      = REQ;
        end
      end
      REQ: begin
        rw_d   = core_rw[owner_q];
        data_d = data_arr[owner_q];
        if (bus_grant) begin
          grant_d = NUM_CORES'(1) << owner_q;
          cnt_d   = '0;
          state_d = OWN;
        end else if (req_drop) begin
          // Aborted request does not consume the core's turn
          req_d   = 1'b0;
          owner_d = prev_owner_q;
          state_d = IDLE;
        end
      end
      OWN: begin
        rw_d   = core_rw[owner_q];
        data_d = data_arr[owner_q];
        if (done_hit || req_drop || limit_hit) begin
          req_d     = 1'b0;
          grant_d   = '0;
          timeout_d = limit_hit && !done_hit && !req_drop;
          state_d   = RELEASE;
        end else begin
          cnt_d = (cnt_q == CNT_W'(HOLD_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= ID_W'(NUM_CORES - 1);
      prev_owner_q <= ID_W'(NUM_CORES - 1);
      cnt_q        <= '0;
      req_q        <= 1'b0;
      rw_q         <= 1'b0;
      data_q       <= '0;
      grant_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      prev_owner_q <= prev_owner_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      rw_q         <= rw_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus_request = req_q;
  assign bus_rw_req  = rw_q;
  assign bus_data_in = data_q;
  assign core_grant  = grant_q;
  assign owner_id    = owner_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_smp_bus_arbiter.sv
// tb/tb_smp_bus_arbiter.sv - scoreboard bench for smp_bus_arbiter
module tb_smp_bus_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int HM = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   core_req, core_rw, core_done;
  logic [N*W-1:0] core_data;
  logic           bus_grant;
  logic           bus_request, bus_rw_req, timeout;
  logic [W-1:0]   bus_data_in;
  logic [N-1:0]   core_grant;
  logic [1:0]     owner_id;

  smp_bus_arbiter #(.NUM_CORES(N), .DATA_W(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_rw(core_rw),
    .core_data(core_data), .core_done(core_done), .bus_grant(bus_grant),
    .bus_request(bus_request), .bus_rw_req(bus_rw_req), .bus_data_in(bus_data_in),
    .core_grant(core_grant), .owner_id(owner_id), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  typedef enum int {EV_START, EV_END, EV_TO} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [N-1:0] grant;
    logic [1:0] owner;
    logic [W-1:0] data;
    logic       rw;
    int         len;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_start = 0, n_end = 0, n_to = 0;
  logic       grant_en;
  logic [N-1:0] done_mask;
  int         done_after;
  logic [W-1:0] cdata [N];
  logic       crw [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_data();
    for (int i = 0; i < N; i++) begin
      core_data[i*W +: W] = cdata[i];
      core_rw[i]          = crw[i];
    end
  endtask

  task automatic push_grant(input int c, input int len);
    ev_t e;
    e.kind = EV_START; e.grant = N'(1) << c; e.owner = 2'(c);
    e.data = cdata[c]; e.rw = crw[c]; e.len = 0;
    exp_q.push_back(e);
    e.kind = EV_END; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic push_timeout(input int c);
    ev_t e;
    e.kind = EV_TO; e.grant = '0; e.owner = 2'(c); e.data = '0; e.rw = 1'b0; e.len = 0;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input string name, input int which, input int target, input int budget);
    int cur;
    for (int i = 0; i < budget; i++) begin
      step();
      cur = (which == 0) ? n_start : (which == 1) ? n_end : n_to;
      if (cur >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, count %0d required %0d", name, cur, target);
  endtask

  // Bus interface model: grant follows bus_request with one cycle of latency
  initial begin
    logic br;
    bus_grant = 1'b0;
    forever begin
      @(negedge clk);
      br = bus_request & grant_en;
      @(posedge clk);
      #1 bus_grant = br;
    end
  end

  // Core responder: pulses done after done_after cycles of grant on masked cores
  initial begin
    int k;
    k = 0;
    core_done = '0;
    forever begin
      @(negedge clk);
      if (core_grant != '0) k++;
      else k = 0;
      if (k == done_after && (core_grant & done_mask) != '0) begin
        @(posedge clk);
        #1 core_done = core_grant;
        @(posedge clk);
        #1 core_done = '0;
        k = 0;
      end
    end
  end

  // Monitor: compares every grant start, grant end and timeout pulse against the queue
  initial begin
    logic [N-1:0] prev;
    int           len;
    ev_t          e;
    prev = '0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (core_grant != '0 && prev == '0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got grant %0h expected none", core_grant);
        end else begin
          e = exp_q.pop_front();
          chk("start_kind", 64'(EV_START), 64'(e.kind));
          chk("start_grant", 64'(core_grant), 64'(e.grant));
          chk("start_owner", 64'(owner_id), 64'(e.owner));
          chk("start_data", 64'(bus_data_in), 64'(e.data));
          chk("start_rw", 64'(bus_rw_req), 64'(e.rw));
        end
        n_start++;
        len = 1;
      end else if (core_grant != '0) begin
        len++;
      end
      if (prev != '0 && core_grant == '0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end: got len %0d expected none", len);
        end else begin
          e = exp_q.pop_front();
          chk("end_kind", 64'(EV_END), 64'(e.kind));
          chk("end_len", 64'(len), 64'(e.len));
        end
        n_end++;
      end
      if (timeout) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_timeout: got owner %0d expected none", owner_id);
        end else begin
          e = exp_q.pop_front();
          chk("to_kind", 64'(EV_TO), 64'(e.kind));
          chk("to_owner", 64'(owner_id), 64'(e.owner));
        end
        n_to++;
      end
      prev = core_grant;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed stimulus
  initial begin
    reset      = 1'b0;
    grant_en   = 1'b1;
    done_mask  = '1;
    done_after = 2;
    for (int i = 0; i < N; i++) begin
      cdata[i] = 32'hA000_0000 | i;
      crw[i]   = i[0];
    end
    apply_data();
    core_req = 4'hF;

    // Reset held with all requests up
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_request", 64'(bus_request), 64'd0);
    chk("rst_bus_rw_req", 64'(bus_rw_req), 64'd0);
    chk("rst_bus_data_in", 64'(bus_data_in), 64'd0);
    chk("rst_core_grant", 64'(core_grant), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_owner_id", 64'(owner_id), 64'd3);

    // Round robin with all cores requesting
    for (int c = 0; c < 4; c++) push_grant(c, 3);
    push_grant(0, 3);
    step();
    reset = 1'b1;
    wait_ev("rr_done", 1, 5, 400);
    core_req = '0;
    repeat (3) step();

    // Single core, exact cycle timing
    cdata[2] = 32'hDEADBEEF;
    crw[2]   = 1'b1;
    apply_data();
    core_req = 4'b0100;
    push_grant(2, 3);
    @(negedge clk);
    chk("sc_c0_bus_request", 64'(bus_request), 64'd0);
    @(negedge clk);
    chk("sc_c1_bus_request", 64'(bus_request), 64'd1);
    @(negedge clk);
    chk("sc_c2_bus_grant", 64'(bus_grant), 64'd1);
    chk("sc_c2_core_grant", 64'(core_grant), 64'd0);
    @(negedge clk);
    chk("sc_c3_core_grant", 64'(core_grant), 64'b0100);
    chk("sc_c3_data", 64'(bus_data_in), 64'hDEADBEEF);
    chk("sc_c3_rw", 64'(bus_rw_req), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("sc_c5_core_grant", 64'(core_grant), 64'b0100);
    @(negedge clk);
    chk("sc_c6_core_grant", 64'(core_grant), 64'd0);
    chk("sc_c6_bus_request", 64'(bus_request), 64'd0);
    core_req = '0;
    repeat (3) step();

    // Hold timeout on core 1, core 2 next
    done_mask = 4'b0100;
    core_req  = 4'b0110;
    push_grant(1, HM);
    exp_q.pop_back();
    begin
      ev_t e;
      e.kind = EV_END; e.grant = '0; e.owner = 2'd1; e.data = '0; e.rw = 1'b0; e.len = HM;
      exp_q.push_back(e);
    end
    push_timeout(1);
    push_grant(2, 3);
    wait_ev("to_pulse", 2, 1, 100);
    core_req = 4'b0100;
    wait_ev("to_next_done", 1, 8, 100);
    core_req = '0;
    repeat (3) step();

    // Abort in REQ: core 3 drops before grant, core 0 pending
    done_mask = '1;
    grant_en  = 1'b0;
    core_req  = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    chk("ab_c1_bus_request", 64'(bus_request), 64'd1);
    chk("ab_c1_owner_id", 64'(owner_id), 64'd3);
    core_req = 4'b0001;
    @(negedge clk);
    chk("ab_c2_bus_request", 64'(bus_request), 64'd0);
    chk("ab_c2_core_grant", 64'(core_grant), 64'd0);
    chk("ab_c2_owner_id", 64'(owner_id), 64'd2);
    grant_en = 1'b1;
    push_grant(0, 3);
    wait_ev("ab_done", 1, 9, 100);
    core_req = '0;
    repeat (3) step();

    // Reset while core 0 owns the bus
    done_mask = '0;
    core_req  = 4'b0001;
    push_grant(0, 2);
    push_grant(0, 3);
    wait_ev("mr_grant", 0, 10, 100);
    reset = 1'b0;
    step();
    done_mask = 4'b0001;
    @(negedge clk);
    chk("mr_core_grant", 64'(core_grant), 64'd0);
    chk("mr_bus_request", 64'(bus_request), 64'd0);
    chk("mr_owner_id", 64'(owner_id), 64'd3);
    chk("mr_timeout", 64'(timeout), 64'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("mr_idle_bus_request", 64'(bus_request), 64'd0);
    @(negedge clk);
    chk("mr_req_bus_request", 64'(bus_request), 64'd1);
    chk("mr_req_owner_id", 64'(owner_id), 64'd0);
    wait_ev("mr_done", 1, 11, 100);
    core_req = '0;
    repeat (3) step();

    // Done coinciding with the hold limit counts as done, no timeout
    done_after = HM - 1;
    done_mask  = '1;
    core_req   = 4'b1000;
    push_grant(3, HM);
    wait_ev("lim_done", 1, 12, 100);
    core_req = '0;
    repeat (4) step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("timeout_total", 64'(n_to), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
